// File: rtl/ccc_lock_reset_seq.sv
// ============================================================================
// Module   : ccc_lock_reset_seq
// Brief    : Synchronizes and qualifies the CCC FAB_LOCK, sequences a
//            glitch-free fabric reset release and keeps lock-loss status.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ccc_lock_reset_seq #(
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_FILTER = 16,
    parameter int RELEASE_DLY = 256,
    parameter int CNT_W       = 8
) (
    input  logic             FAB_CLK,
    input  logic             M2F_RESET_N,
    input  logic             FAB_LOCK,
    input  logic             SW_RESET,
    input  logic             CLR_STATUS,
    output logic             FABRIC_RESET_N,
    output logic             LOCK_LOST,
    output logic [CNT_W-1:0] LOSS_COUNT,
    output logic [1:0]       STATE
);

    localparam int c_CNT_MAX = (LOCK_FILTER > RELEASE_DLY) ? LOCK_FILTER : RELEASE_DLY;
    localparam int c_CW      = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;

    localparam logic [c_CW-1:0]  c_FILT_LAST = c_CW'(LOCK_FILTER - 1);
    localparam logic [c_CW-1:0]  c_DLY_LAST  = c_CW'(RELEASE_DLY - 1);
    localparam logic [CNT_W-1:0] c_LOSS_MAX  = '1;
    localparam logic [CNT_W-1:0] c_LOSS_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_WAIT_LOCK = 2'b00,
        S_FILTER    = 2'b01,
        S_DELAY     = 2'b10,
        S_RUN       = 2'b11
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [c_CW-1:0]        r_cnt;
    logic [c_CW-1:0]        w_cnt_nxt;
    logic                   w_loss;
    logic                   w_lock_s;
    logic                   r_fabric_rst_n;
    logic                   r_lock_lost;
    logic [CNT_W-1:0]       r_loss_cnt;

    assign w_lock_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge FAB_CLK or negedge M2F_RESET_N) begin
        if (!M2F_RESET_N) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], FAB_LOCK};
        end
    end

    always_ff @(posedge FAB_CLK or negedge M2F_RESET_N) begin
        if (!M2F_RESET_N) begin
            r_state        <= S_WAIT_LOCK;
            r_cnt          <= '0;
            r_fabric_rst_n <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            // Registered from next state so the reset output never glitches.
            r_fabric_rst_n <= (w_state_nxt == S_RUN);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_loss      = 1'b0;
        case (r_state)
            S_WAIT_LOCK: begin
                w_cnt_nxt = '0;
                if (w_lock_s) begin
                    w_state_nxt = S_FILTER;
                end
            end
            S_FILTER: begin
                if (!w_lock_s) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_FILT_LAST) begin
                    w_state_nxt = S_DELAY;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_DELAY: begin
                if (!w_lock_s) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_DLY_LAST) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_RUN: begin
                // Lock loss takes priority over a software re-run request.
                if (!w_lock_s) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                    w_loss      = 1'b1;
                end else if (SW_RESET) begin
                    w_state_nxt = S_DELAY;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = S_WAIT_LOCK;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge FAB_CLK or negedge M2F_RESET_N) begin
        if (!M2F_RESET_N) begin
            r_lock_lost <= 1'b0;
            r_loss_cnt  <= '0;
        end else if (w_loss) begin
            r_lock_lost <= 1'b1;
            if (CLR_STATUS) begin
                r_loss_cnt <= c_LOSS_ONE;
            end else if (r_loss_cnt != c_LOSS_MAX) begin
                r_loss_cnt <= r_loss_cnt + 1'b1;
            end
        end else if (CLR_STATUS) begin
            r_lock_lost <= 1'b0;
            r_loss_cnt  <= '0;
        end
    end

    assign FABRIC_RESET_N = r_fabric_rst_n;
    assign LOCK_LOST      = r_lock_lost;
    assign LOSS_COUNT     = r_loss_cnt;
    assign STATE          = r_state;

endmodule

`default_nettype wire

// File: tb/tb_ccc_lock_reset_seq.sv
// ============================================================================
// Module   : tb_ccc_lock_reset_seq
// Brief    : Self-checking bench for ccc_lock_reset_seq against a lock-streak
//            reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ccc_lock_reset_seq;

    localparam int SYNC = 2;
    localparam int LF   = 16;
    localparam int RD   = 256;
    localparam int CW   = 2;
    localparam int CMAX = 3;
    localparam int FULL = LF + RD + 1;

    logic          clk;
    logic          rst_n;
    logic          fab_lock;
    logic          sw;
    logic          clr;
    logic          fab_rst_n;
    logic          lock_lost;
    logic [CW-1:0] loss_count;
    logic [1:0]    state;

    int n_tests;
    int n_fail;

    // Reference model: m_s is the run of consecutive synchronized-high samples.
    logic [SYNC-1:0] m_hist;
    int              m_s;
    logic            m_lost;
    int              m_cnt;

    ccc_lock_reset_seq #(
        .SYNC_STAGES(SYNC),
        .LOCK_FILTER(LF),
        .RELEASE_DLY(RD),
        .CNT_W      (CW)
    ) dut (
        .FAB_CLK       (clk),
        .M2F_RESET_N   (rst_n),
        .FAB_LOCK      (fab_lock),
        .SW_RESET      (sw),
        .CLR_STATUS    (clr),
        .FABRIC_RESET_N(fab_rst_n),
        .LOCK_LOST     (lock_lost),
        .LOSS_COUNT    (loss_count),
        .STATE         (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] dut_vec();
        return {fab_rst_n, state, lock_lost, loss_count};
    endfunction

    function automatic logic [5:0] model_vec();
        logic [1:0] st;
        if (m_s == 0)         st = 2'b00;
        else if (m_s <= LF)   st = 2'b01;
        else if (m_s < FULL)  st = 2'b10;
        else                  st = 2'b11;
        return {(m_s >= FULL), st, m_lost, 2'(m_cnt)};
    endfunction

    task automatic model_reset();
        m_hist = '0;
        m_s    = 0;
        m_lost = 1'b0;
        m_cnt  = 0;
    endtask

    task automatic model_update();
        logic ls;
        logic rel;
        if (!rst_n) begin
            model_reset();
        end else begin
            ls     = m_hist[SYNC-1];
            rel    = (m_s >= FULL);
            m_hist = {m_hist[SYNC-2:0], fab_lock};
            if (!ls) begin
                if (rel) begin
                    m_lost = 1'b1;
                    m_cnt  = clr ? 1 : ((m_cnt < CMAX) ? m_cnt + 1 : CMAX);
                end else if (clr) begin
                    m_lost = 1'b0;
                    m_cnt  = 0;
                end
                m_s = 0;
            end else begin
                if (clr) begin
                    m_lost = 1'b0;
                    m_cnt  = 0;
                end
                if (rel && sw)       m_s = LF + 1;
                else if (m_s < FULL) m_s = m_s + 1;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b1; fab_lock = 1'b0; sw = 1'b0; clr = 1'b0;
        model_reset();
        #1 rst_n = 1'b0;
        step();
        step();
        n_tests++;
        if (fab_rst_n !== 1'b0) begin n_fail++; $display("FAIL reset_fabric_rst_n: got %b expected 0", fab_rst_n); end
        n_tests++;
        if (state !== 2'b00) begin n_fail++; $display("FAIL reset_state: got %b expected 00", state); end
        n_tests++;
        if ({lock_lost, loss_count} !== 3'b000) begin
            n_fail++; $display("FAIL reset_status: got %b expected 000", {lock_lost, loss_count});
        end
    endtask

    task automatic test_power_up();
        rst_n = 1'b1; fab_lock = 1'b1;
        for (int e = 1; e <= 275; e++) begin
            step();
            n_tests++;
            if (dut_vec() !== model_vec()) begin
                n_fail++; $display("FAIL power_up edge %0d: got %b expected %b", e, dut_vec(), model_vec());
            end
            if (e == 3 || e == 19 || e == 275) begin
                n_tests++;
                if (state !== ((e == 3) ? 2'b01 : (e == 19) ? 2'b10 : 2'b11)) begin
                    n_fail++; $display("FAIL power_up_state edge %0d: got %b", e, state);
                end
            end
            if (e == 274 || e == 275) begin
                n_tests++;
                if (fab_rst_n !== (e == 275)) begin
                    n_fail++; $display("FAIL power_up_release edge %0d: got %b expected %b", e, fab_rst_n, (e == 275));
                end
            end
        end
    endtask

    task automatic test_loss_in_run();
        fab_lock = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            step();
            n_tests++;
            if (dut_vec() !== model_vec()) begin
                n_fail++; $display("FAIL loss edge %0d: got %b expected %b", e, dut_vec(), model_vec());
            end
        end
        n_tests++;
        if ({fab_rst_n, lock_lost, loss_count} !== 4'b0101) begin
            n_fail++; $display("FAIL loss_edge3: got %b expected 0101", {fab_rst_n, lock_lost, loss_count});
        end
        fab_lock = 1'b1;
        for (int e = 1; e <= 275; e++) begin
            step();
            n_tests++;
            if (dut_vec() !== model_vec()) begin
                n_fail++; $display("FAIL relock edge %0d: got %b expected %b", e, dut_vec(), model_vec());
            end
        end
        n_tests++;
        if (fab_rst_n !== 1'b1) begin n_fail++; $display("FAIL relock_release: got %b expected 1", fab_rst_n); end
    endtask

    task automatic test_glitchy_lock();
        int hi;
        fab_lock = 1'b0;
        for (int i = 0; i < 5; i++) step();
        hi = $urandom_range(4, 15);
        fab_lock = 1'b1;
        for (int i = 0; i < hi; i++) step();
        fab_lock = 1'b0;
        step();
        fab_lock = 1'b1;
        for (int e = 1; e <= 275; e++) begin
            step();
            n_tests++;
            if (dut_vec() !== model_vec()) begin
                n_fail++; $display("FAIL glitch edge %0d: got %b expected %b", e, dut_vec(), model_vec());
            end
            if (e == 274 || e == 275) begin
                n_tests++;
                if (fab_rst_n !== (e == 275)) begin
                    n_fail++; $display("FAIL glitch_release edge %0d: got %b expected %b", e, fab_rst_n, (e == 275));
                end
            end
        end
        n_tests++;
        if (loss_count !== 2'd2) begin n_fail++; $display("FAIL glitch_loss_count: got %0d expected 2", loss_count); end
    endtask

    task automatic test_sw_reset();
        int low;
        int r;
        for (int pass = 0; pass < 2; pass++) begin
            r = (pass == 0) ? -1 : int'($urandom_range(10, 200));
            sw = 1'b1;
            step();
            sw = 1'b0;
            low = 0;
            while (fab_rst_n === 1'b0 && low < 400) begin
                low++;
                sw = (low == r);
                step();
                n_tests++;
                if (dut_vec() !== model_vec()) begin
                    n_fail++; $display("FAIL sw_reset pass %0d cycle %0d: got %b expected %b", pass, low, dut_vec(), model_vec());
                end
            end
            sw = 1'b0;
            n_tests++;
            if (low != RD) begin n_fail++; $display("FAIL sw_reset_low pass %0d: got %0d cycles expected %0d", pass, low, RD); end
        end
    endtask

    task automatic test_saturation();
        clr = 1'b1;
        step();
        clr = 1'b0;
        n_tests++;
        if ({lock_lost, loss_count} !== 3'b000) begin
            n_fail++; $display("FAIL clear_alone: got %b expected 000", {lock_lost, loss_count});
        end
        for (int i = 0; i < 5; i++) begin
            fab_lock = 1'b0;
            for (int k = 0; k < 4; k++) step();
            fab_lock = 1'b1;
            for (int k = 0; k < 275; k++) begin
                step();
                n_tests++;
                if (dut_vec() !== model_vec()) begin
                    n_fail++; $display("FAIL saturate loss %0d cycle %0d: got %b expected %b", i, k, dut_vec(), model_vec());
                end
            end
        end
        n_tests++;
        if ({lock_lost, loss_count} !== 3'b111) begin
            n_fail++; $display("FAIL saturate_count: got %b expected 111", {lock_lost, loss_count});
        end
        fab_lock = 1'b0;
        step();
        step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        n_tests++;
        if ({fab_rst_n, lock_lost, loss_count} !== 4'b0101) begin
            n_fail++; $display("FAIL clear_with_loss: got %b expected 0101", {fab_rst_n, lock_lost, loss_count});
        end
    endtask

    task automatic test_random();
        int len;
        for (int seg = 0; seg < 16; seg++) begin
            fab_lock = seg[0];
            if (fab_lock) len = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 24)) : int'($urandom_range(280, 420));
            else          len = $urandom_range(1, 6);
            for (int k = 0; k < len; k++) begin
                sw  = ($urandom_range(0, 59) == 0);
                clr = ($urandom_range(0, 39) == 0);
                step();
                n_tests++;
                if (dut_vec() !== model_vec()) begin
                    n_fail++; $display("FAIL random seg %0d cycle %0d: got %b expected %b", seg, k, dut_vec(), model_vec());
                end
            end
        end
        sw = 1'b0;
        clr = 1'b0;
    endtask

    task automatic test_async_reset();
        fab_lock = 1'b0;
        for (int k = 0; k < 4; k++) step();
        fab_lock = 1'b1;
        for (int k = 0; k < 119; k++) step();
        n_tests++;
        if (state !== 2'b10) begin n_fail++; $display("FAIL async_pre_state: got %b expected 10", state); end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        n_tests++;
        if (dut_vec() !== 6'b000000) begin
            n_fail++; $display("FAIL async_reset_outputs: got %b expected 000000", dut_vec());
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 275; e++) begin
            step();
            n_tests++;
            if (dut_vec() !== model_vec()) begin
                n_fail++; $display("FAIL async_restart edge %0d: got %b expected %b", e, dut_vec(), model_vec());
            end
            if (e == 274 || e == 275) begin
                n_tests++;
                if (fab_rst_n !== (e == 275)) begin
                    n_fail++; $display("FAIL async_restart_release edge %0d: got %b expected %b", e, fab_rst_n, (e == 275));
                end
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_power_up();
        test_loss_in_run();
        test_glitchy_lock();
        test_sw_reset();
        test_saturation();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
